// File: rtl/dotp_pkg.sv
// rtl/dotp_pkg.sv - shared FSM encoding and configuration check for the dot-product engine
package dotp_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_A = 3'd1,
        LOAD_B = 3'd2,
        MAC    = 3'd3,
        STORE  = 3'd4,
        DONE   = 3'd5
    } state_t;

    // The accumulator must hold a full signed product without truncation.
    function automatic bit acc_width_ok(input int acc_w, input int data_w);
        return acc_w >= 2 * data_w;
    endfunction

endpackage

// File: rtl/dotp_mac.sv
// rtl/dotp_mac.sv - signed multiply-accumulate; DOTP_SAT_EN selects saturating accumulate with sticky ovf
module dotp_mac #(
    parameter int DATA_W = 32,
    parameter int ACC_W  = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] op_a,
    input  logic signed [DATA_W-1:0] op_b,
    output logic signed [ACC_W-1:0]  acc,
    output logic                     ovf
);

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext;

    assign prod     = op_a * op_b;
    assign prod_ext = ACC_W'(prod);

`ifdef DOTP_SAT_EN
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    // One guard bit: the two top bits disagree exactly when the sum left the signed range.
    logic [ACC_W:0] sum;
    assign sum = {acc[ACC_W-1], acc} + {prod_ext[ACC_W-1], prod_ext};

    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (clear) begin
            acc <= '0;
            ovf <= 1'b0;
        end else if (en) begin
            if (sum[ACC_W] != sum[ACC_W-1]) begin
                acc <= sum[ACC_W] ? ACC_MIN : ACC_MAX;
                ovf <= 1'b1;
            end else begin
                acc <= sum[ACC_W-1:0];
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (rst) begin
            acc <= '0;
        end else if (clear) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + prod_ext;
        end
    end

    assign ovf = 1'b0;
`endif

endmodule

// File: rtl/dot_product_engine.sv
// rtl/dot_product_engine.sv - memory-mapped dot-product accelerator: FSM, pointers, counter, memory handshake (DOTP_SAT_EN in dotp_mac)
module dot_product_engine
    import dotp_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 8,
    parameter int LEN_W  = 8,
    parameter int ACC_W  = 64
) (
    input  logic              clk18,
    input  logic              rst18,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [ADDR_W-1:0] base_a,
    input  logic [ADDR_W-1:0] base_b,
    input  logic [ADDR_W-1:0] stride,
    input  logic [ADDR_W-1:0] dst_addr,
    output logic              busy,
    output logic              done,
    output logic [ACC_W-1:0]  result,
    output logic              ovf,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    if (!acc_width_ok(ACC_W, DATA_W)) begin : g_bad_cfg
        $error("dot_product_engine: ACC_W must be at least 2*DATA_W");
    end

    state_t state, state_next;

    logic [ADDR_W-1:0]        a_ptr, b_ptr, stride_q, dst_q;
    logic [LEN_W-1:0]         cnt;
    logic signed [DATA_W-1:0] op_a, op_b;
    logic signed [ACC_W-1:0]  acc;
    logic                     accept;
    logic                     mac_en;

    assign accept = (state == IDLE) && start;
    assign mac_en = (state == MAC);

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        case (state)
            IDLE: begin
                if (start) state_next = (len == '0) ? STORE : LOAD_A;
            end
            LOAD_A: begin
                busy     = 1'b1;
                mem_req  = 1'b1;
                mem_addr = a_ptr;
                if (mem_ack) state_next = LOAD_B;
            end
            LOAD_B: begin
                busy     = 1'b1;
                mem_req  = 1'b1;
                mem_addr = b_ptr;
                if (mem_ack) state_next = MAC;
            end
            MAC: begin
                busy       = 1'b1;
                state_next = (cnt == LEN_W'(1)) ? STORE : LOAD_A;
            end
            STORE: begin
                busy      = 1'b1;
                mem_req   = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = dst_q;
                mem_wdata = acc[DATA_W-1:0];
                if (mem_ack) state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk18) begin
        if (rst18) begin
            state    <= IDLE;
            a_ptr    <= '0;
            b_ptr    <= '0;
            stride_q <= '0;
            dst_q    <= '0;
            cnt      <= '0;
            op_a     <= '0;
            op_b     <= '0;
            result   <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                a_ptr    <= base_a;
                b_ptr    <= base_b;
                stride_q <= stride;
                dst_q    <= dst_addr;
                cnt      <= len;
            end
            if (state == LOAD_A && mem_ack) op_a <= mem_rdata;
            if (state == LOAD_B && mem_ack) op_b <= mem_rdata;
            // Pointers wrap naturally at ADDR_W bits.
            if (mac_en) begin
                a_ptr <= a_ptr + stride_q;
                b_ptr <= b_ptr + stride_q;
                cnt   <= cnt - LEN_W'(1);
            end
            if (state == STORE && mem_ack) result <= acc;
        end
    end

    dotp_mac #(
        .DATA_W(DATA_W),
        .ACC_W (ACC_W)
    ) u_mac (
        .clk  (clk18),
        .rst  (rst18),
        .clear(accept),
        .en   (mac_en),
        .op_a (op_a),
        .op_b (op_b),
        .acc  (acc),
        .ovf  (ovf)
    );

endmodule
